mfcc_feature_buffer: RTL and testbench
======================================

Name: mfcc_feature_buffer

Overview:
- Supplier end of the recogniser's MFCC read interface: the recogniser drives mfcc_addr and samples mfcc_data.
- Accepts a stream of 32-bit MFCC coefficients from the feature extractor into a ping-pong buffer of two 128-word banks.
- Presents one completed bank to the recogniser with a ready/done handshake, while the extractor fills the other bank.

Parameters:
- DATA_W, 32, coefficient width.
- ADDR_W, 7, read/write address width per bank; DEPTH = 2**ADDR_W = 128 words per bank.

Ports:
- clk_sys  in  1  system clock, 50 MHz; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  extractor presents wr_data.
- wr_data  in  DATA_W  coefficient word.
- wr_last  in  1  current word is the final word of the utterance (qualified by wr_valid).
- wr_ready  out  1  buffer can accept a word this cycle.
- mfcc_addr  in  ADDR_W  recogniser read address.
- mfcc_data  out  DATA_W  read data, registered.
- feat_ready  out  1  a full bank is available to the recogniser (level).
- frame_len  out  ADDR_W+1  number of valid words in the presented bank, range 1..128.
- rd_done  in  1  one-cycle pulse: recogniser has finished with the presented bank.
- ovf  out  1  sticky flag: a write was attempted while wr_ready=0.

Behaviour:
- Reset:
  - Both banks EMPTY; wb=0, rb=0, wr_ptr=0.
  - wr_ready=1, feat_ready=0, frame_len=0, mfcc_data=0, ovf=0.
  - RAM contents are not cleared.
- Bank states: EMPTY, FILLING, FULL.
  - Write side cycles wb through EMPTY->FILLING->FULL.
  - Read side releases rb from FULL->EMPTY.
- Write:
  - wr_ready = (bank[wb] != FULL).
  - A word is accepted when wr_valid & wr_ready. It is stored at {wb, wr_ptr}; wr_ptr then increments.
  - The first accepted word moves the bank EMPTY->FILLING.
- Bank completion: triggered by an accepted word with wr_last=1, or by acceptance at wr_ptr=DEPTH-1.
  - len[wb] = wr_ptr+1 and bank[wb] becomes FULL.
  - wb toggles and wr_ptr returns to 0.
  - wr_last on the first word of a bank gives length 1.
- Overflow: wr_valid=1 with wr_ready=0 sets ovf. Only reset clears it. The word is dropped.
- Read handshake:
  - feat_ready = (bank[rb] == FULL); frame_len = len[rb] while feat_ready=1, else 0.
  - rd_done with feat_ready=1: bank[rb] becomes EMPTY and rb toggles. feat_ready drops the next cycle unless the other bank is already FULL, in which case it stays 1 and frame_len updates.
  - rd_done with feat_ready=0 is ignored.
- Read data:
  - mfcc_data = RAM[{rb, mfcc_addr}] when feat_ready=1, registered, 1-cycle latency. Otherwise mfcc_data = 0 on the next cycle.
  - Addresses >= frame_len return stale contents; there is no masking.
- Simultaneous events:
  - Completion of bank wb and rd_done on bank rb in the same cycle both take effect.
  - When the buffer is full (both banks FULL), rd_done frees rb; wr_ready rises the next cycle.
- Reset mid-operation (either side): all state returns to the reset values within the same cycle. A partially filled bank is discarded.

Decomposition:
- Package mfcc_buf_pkg: DATA_W and ADDR_W constants, DEPTH, and the bank-state enum (EMPTY/FILLING/FULL).
- Sub-module mfcc_dp_ram: simple dual-port RAM with synchronous read.
  - Depth 2*DEPTH, address {bank, addr}; one write port and one read port.
  - Inferable as M4K on the DE2 board.
- Control FSM and pointers live in the top module.

Test Plan:
- Fill bank: write 128 words 0x100+i with no wr_last -> feat_ready=1 the next cycle, frame_len=128. Reading addr 5 returns 0x105 one cycle later.
- Short utterance: write 20 words, wr_last on word 20 -> frame_len=20, feat_ready=1. rd_done -> feat_ready=0 the next cycle.
- Ping-pong: fill bank0 (len 10), then fill bank1 (len 30) while reading bank0; rd_done -> feat_ready stays 1, frame_len=30, addr 0 returns the first bank1 word.
- Full stall: fill both banks -> wr_ready=0. A further wr_valid sets ovf=1; rd_done -> wr_ready=1 the next cycle, and ovf stays 1.
- Same-cycle events: assert rd_done on bank0 in the same cycle as the completing write of bank1 -> bank0 EMPTY, rb=1, feat_ready=1, frame_len = bank1 length.
- Reset mid-fill: after 50 words, pulse rst_n low -> wr_ready=1, feat_ready=0, frame_len=0, mfcc_data=0. The next fill starts at address 0.

Source files
------------

// File: rtl/mfcc_buf_pkg.sv
// ============================================================================
//  Module   : mfcc_buf_pkg
//  Purpose  : Shared widths and bank-state encoding for the MFCC ping-pong buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfcc_buf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage : mfcc_buf_pkg

`default_nettype wire

// File: rtl/mfcc_feature_buffer_if.sv
// ============================================================================
//  Module   : mfcc_feature_buffer_if
//  Purpose  : Extractor write stream plus recogniser read bus of the buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mfcc_feature_buffer_if;
  import mfcc_buf_pkg::*;

  // Write side (feature extractor -> buffer)
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;

  // Read side (recogniser <-> buffer)
  logic [ADDR_W-1:0] mfcc_addr;
  logic [DATA_W-1:0] mfcc_data;
  logic              feat_ready;
  logic [ADDR_W:0]   frame_len;
  logic              rd_done;

  logic              ovf;

  modport slave (
    input  wr_valid, wr_data, wr_last, mfcc_addr, rd_done,
    output wr_ready, mfcc_data, feat_ready, frame_len, ovf
  );

  modport master (
    output wr_valid, wr_data, wr_last, mfcc_addr, rd_done,
    input  wr_ready, mfcc_data, feat_ready, frame_len, ovf
  );

endinterface : mfcc_feature_buffer_if

`default_nettype wire

// File: rtl/mfcc_dp_ram.sv
// ============================================================================
//  Module   : mfcc_dp_ram
//  Purpose  : Simple dual-port RAM, one write and one synchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfcc_dp_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  wire logic              clk_i,
  input  wire logic              we_i,
  input  wire logic [AW-1:0]     waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [AW-1:0]     raddr_i,
  output logic      [DATA_W-1:0] rdata_o
);

  localparam int NWORDS = 1 << AW;

  // No reset on the array or read register so the block maps onto embedded RAM.
  logic [DATA_W-1:0] mem [NWORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : mfcc_dp_ram

`default_nettype wire

// File: rtl/mfcc_feature_buffer.sv
// ============================================================================
//  Module   : mfcc_feature_buffer
//  Purpose  : Two-bank ping-pong buffer between MFCC extractor and recogniser.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfcc_feature_buffer
  import mfcc_buf_pkg::*;
(
  input  wire logic            clk_sys,
  input  wire logic            rst_n,
  mfcc_feature_buffer_if.slave bus
);

  bank_state_e [1:0]          bank_q, bank_d;
  logic [1:0][ADDR_W:0]       len_q, len_d;
  logic                       wb_q, wb_d;
  logic                       rb_q, rb_d;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic                       ovf_q, ovf_d;
  logic                       rd_vld_q;

  logic                       wr_ready;
  logic                       wr_fire;
  logic                       wr_complete;
  logic                       feat_ready;
  logic                       rd_fire;
  logic [DATA_W-1:0]          ram_rdata;

  assign wr_ready    = (bank_q[wb_q] != BANK_FULL);
  assign wr_fire     = bus.wr_valid & wr_ready;
  assign wr_complete = wr_fire & (bus.wr_last | (wr_ptr_q == ADDR_W'(DEPTH - 1)));
  assign feat_ready  = (bank_q[rb_q] == BANK_FULL);
  assign rd_fire     = bus.rd_done & feat_ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      len_q     <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wr_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      len_q     <= len_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wr_ptr_q  <= wr_ptr_d;
      ovf_q     <= ovf_d;
      rd_vld_q  <= feat_ready;
    end
  end

  // Read release and write completion always target different banks: a read
  // needs bank[rb] FULL while a write needs bank[wb] not FULL.
  always_comb begin
    bank_d   = bank_q;
    len_d    = len_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;

    if (rd_fire) begin
      bank_d[rb_q] = BANK_EMPTY;
      rb_d         = ~rb_q;
    end

    if (wr_fire) begin
      if (wr_complete) begin
        bank_d[wb_q] = BANK_FULL;
        len_d[wb_q]  = (ADDR_W + 1)'(wr_ptr_q) + (ADDR_W + 1)'(1);
        wb_d         = ~wb_q;
        wr_ptr_d     = '0;
      end else begin
        bank_d[wb_q] = BANK_FILLING;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
      end
    end

    if (bus.wr_valid && !wr_ready) begin
      ovf_d = 1'b1;
    end
  end

  mfcc_dp_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk_i   (clk_sys),
    .we_i    (wr_fire),
    .waddr_i ({wb_q, wr_ptr_q}),
    .wdata_i (bus.wr_data),
    .raddr_i ({rb_q, bus.mfcc_addr}),
    .rdata_o (ram_rdata)
  );

  assign bus.wr_ready   = wr_ready;
  assign bus.feat_ready = feat_ready;
  assign bus.frame_len  = feat_ready ? len_q[rb_q] : '0;
  assign bus.mfcc_data  = rd_vld_q ? ram_rdata : '0;
  assign bus.ovf        = ovf_q;

endmodule : mfcc_feature_buffer

`default_nettype wire

// File: tb/tb_mfcc_feature_buffer.sv
// ============================================================================
//  Module   : tb_mfcc_feature_buffer
//  Purpose  : Directed vector bench for the MFCC ping-pong feature buffer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfcc_feature_buffer;

  logic clk_sys;
  logic rst_n;
  int   n_chk;
  int   n_err;

  mfcc_feature_buffer_if bus ();

  mfcc_feature_buffer dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk_sys = 1'b0;
  always #10 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        wv;
    logic [31:0] wd;
    logic        wl;
    logic [6:0]  addr;
    logic        rd;
    logic        e_wrdy;
    logic        e_feat;
    logic [7:0]  e_len;
    logic [31:0] e_data;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wv, input logic [31:0] wd, input logic wl,
                     input logic [6:0] addr, input logic rd, input logic e_wrdy,
                     input logic e_feat, input logic [7:0] e_len,
                     input logic [31:0] e_data, input logic e_ovf);
    vec_t v;
    v = '{wv, wd, wl, addr, rd, e_wrdy, e_feat, e_len, e_data, e_ovf};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wd, input logic wl,
                       input logic [6:0] addr, input logic rd);
    bus.wr_valid  = wv;
    bus.wr_data   = wd;
    bus.wr_last   = wl;
    bus.mfcc_addr = addr;
    bus.rd_done   = rd;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must already be clean.
  task automatic do_reset(input string tag);
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk({tag, " wr_ready"},   32'(bus.wr_ready),   32'd1);
    chk({tag, " feat_ready"}, 32'(bus.feat_ready), 32'd0);
    chk({tag, " frame_len"},  32'(bus.frame_len),  32'd0);
    chk({tag, " mfcc_data"},  bus.mfcc_data,       32'd0);
    chk({tag, " ovf"},        32'(bus.ovf),        32'd0);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b0);
    #1;

    // Bank0 len 3, bank1 len 2, stall/overflow, release, same-cycle events
    //   wv  data          wl    addr  rd    wrdy  feat  len   data          ovf
    add(1'b1, 32'h0000_00A0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b0);
    add(1'b1, 32'h0000_00A1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b0);
    add(1'b1, 32'h0000_00A2, 1'b1, 7'd0, 1'b0, 1'b1, 1'b1, 8'd3, 32'h0,        1'b0);
    add(1'b1, 32'h0000_00B0, 1'b0, 7'd1, 1'b0, 1'b1, 1'b1, 8'd3, 32'h0000_00A1, 1'b0);
    add(1'b1, 32'h0000_00B1, 1'b1, 7'd2, 1'b0, 1'b0, 1'b1, 8'd3, 32'h0000_00A2, 1'b0);
    add(1'b1, 32'h0000_DEAD, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 8'd3, 32'h0000_00A0, 1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 8'd2, 32'h0000_00A0, 1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd0, 1'b0, 1'b1, 1'b1, 8'd2, 32'h0000_00B0, 1'b1);
    add(1'b1, 32'h0000_00C0, 1'b0, 7'd1, 1'b0, 1'b1, 1'b1, 8'd2, 32'h0000_00B1, 1'b1);
    add(1'b1, 32'h0000_00C1, 1'b0, 7'd1, 1'b0, 1'b1, 1'b1, 8'd2, 32'h0000_00B1, 1'b1);
    add(1'b1, 32'h0000_00C2, 1'b1, 7'd0, 1'b1, 1'b1, 1'b1, 8'd3, 32'h0000_00B0, 1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd2, 1'b0, 1'b1, 1'b1, 8'd3, 32'h0000_00C2, 1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0000_00C0, 1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1);
    add(1'b0, 32'h0,         1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1);

    do_reset("reset0");

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].wl, tbl[i].addr, tbl[i].rd);
      tick();
      chk($sformatf("v%0d wr_ready", i),   32'(bus.wr_ready),   32'(tbl[i].e_wrdy));
      chk($sformatf("v%0d feat_ready", i), 32'(bus.feat_ready), 32'(tbl[i].e_feat));
      chk($sformatf("v%0d frame_len", i),  32'(bus.frame_len),  32'(tbl[i].e_len));
      chk($sformatf("v%0d mfcc_data", i),  bus.mfcc_data,       tbl[i].e_data);
      chk($sformatf("v%0d ovf", i),        32'(bus.ovf),        32'(tbl[i].e_ovf));
    end

    // Full 128-word bank completes on pointer wrap without wr_last
    do_reset("reset1");
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 7'd0, 1'b0);
      tick();
      if (i == 126) chk("fill127 feat_ready", 32'(bus.feat_ready), 32'd0);
    end
    chk("fill128 feat_ready", 32'(bus.feat_ready), 32'd1);
    chk("fill128 frame_len",  32'(bus.frame_len),  32'd128);
    chk("fill128 wr_ready",   32'(bus.wr_ready),   32'd1);
    drive(1'b0, 32'h0, 1'b0, 7'd5, 1'b0);
    tick();
    chk("fill128 rd addr5", bus.mfcc_data, 32'h105);
    drive(1'b0, 32'h0, 1'b0, 7'd127, 1'b0);
    tick();
    chk("fill128 rd addr127", bus.mfcc_data, 32'h17F);
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b1);
    tick();
    chk("fill128 done feat_ready", 32'(bus.feat_ready), 32'd0);
    chk("fill128 done frame_len",  32'(bus.frame_len),  32'd0);

    // Short utterance in bank1
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h200 + 32'(i), (i == 19), 7'd0, 1'b0);
      tick();
    end
    chk("short feat_ready", 32'(bus.feat_ready), 32'd1);
    chk("short frame_len",  32'(bus.frame_len),  32'd20);
    drive(1'b0, 32'h0, 1'b0, 7'd19, 1'b0);
    tick();
    chk("short rd addr19", bus.mfcc_data, 32'h213);
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b1);
    tick();
    chk("short done feat_ready", 32'(bus.feat_ready), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b0);
    tick();
    chk("short idle mfcc_data", bus.mfcc_data, 32'h0);

    // Reset in the middle of a fill discards the partial bank
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b0, 7'd0, 1'b0);
      tick();
    end
    chk("midfill feat_ready", 32'(bus.feat_ready), 32'd0);
    do_reset("reset2");
    drive(1'b1, 32'h700, 1'b0, 7'd0, 1'b0);
    tick();
    drive(1'b1, 32'h701, 1'b1, 7'd0, 1'b0);
    tick();
    chk("refill feat_ready", 32'(bus.feat_ready), 32'd1);
    chk("refill frame_len",  32'(bus.frame_len),  32'd2);
    drive(1'b0, 32'h0, 1'b0, 7'd0, 1'b0);
    tick();
    chk("refill rd addr0", bus.mfcc_data, 32'h700);
    drive(1'b0, 32'h0, 1'b0, 7'd1, 1'b0);
    tick();
    chk("refill rd addr1", bus.mfcc_data, 32'h701);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_mfcc_feature_buffer

`default_nettype wire
